// File: rtl/enc_pkg.sv
// Shared definitions for the 8-to-3 pending-request encoder.
package enc_pkg;

  localparam int NUM_LINES = 8;
  localparam int CODE_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_LINES-1:0] one_hot(input logic [CODE_W-1:0] code);
    one_hot = 8'd1 << code;
  endfunction

endpackage

// File: rtl/encoder_8_3_pending_pick_8.sv
// Combinational selector: highest-bit encode, or rotating search starting above 'start'.
module pick_8
  import enc_pkg::*;
(
  input  logic [7:0] eligible,
  input  logic [2:0] start,
  input  logic       rr_en,
  output logic       any,
  output logic [2:0] idx
);

  logic [15:0] dbl_s;
  logic [7:0]  rot_s;
  logic [2:0]  off_s;
  logic [2:0]  hit_s;

  // Rotate so the search origin lands on bit 0, encode, then rotate the index back.
  always_comb begin
    off_s = rr_en ? (start + 3'd1) : 3'd0;
    dbl_s = {eligible, eligible} >> off_s;
    rot_s = dbl_s[7:0];
    hit_s = 3'd0;
    if (rr_en) begin
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
        if (rot_s[i]) hit_s = 3'(i);
        else          hit_s = hit_s;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (rot_s[i]) hit_s = 3'(i);
        else          hit_s = hit_s;
      end
    end
    any = |eligible;
    idx = hit_s + off_s;
  end

endmodule

// File: rtl/encoder_8_3_pending.sv
// Sticky request capture with a valid/ack handshake presenting one pending index at a time.
module encoder_8_3_pending
  import enc_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic [7:0] mask_in,
  input  logic       ack_in,
  output logic       valid_out,
  output logic [2:0] code_out,
  output logic [7:0] pending_out
);

  localparam logic RR_EN = 1'(ROUND_ROBIN != 0);

  state_e     state_r, state_nxt;
  logic [7:0] pending_r, pending_nxt, clr_s, pick_vec_s;
  logic [2:0] code_r, code_nxt, last_r, last_nxt, start_s, pick_idx_s;
  logic       valid_r, valid_nxt, pick_any_s;

  // While granting, the candidate set already reflects this edge's clear and new requests.
  always_comb begin
    clr_s       = (valid_r && ack_in) ? one_hot(code_r) : 8'h00;
    pending_nxt = (pending_r & ~clr_s) | req_in;
    if (state_r == GRANT) begin
      pick_vec_s = pending_nxt & ~mask_in;
      start_s    = code_r;
    end else begin
      pick_vec_s = pending_r & ~mask_in;
      start_s    = last_r;
    end
  end

  pick_8 u_pick (
    .eligible (pick_vec_s),
    .start    (start_s),
    .rr_en    (RR_EN),
    .any      (pick_any_s),
    .idx      (pick_idx_s)
  );

  // Grant FSM: hold the code until acknowledged, then chain straight into the next one.
  always_comb begin
    state_nxt = state_r;
    valid_nxt = valid_r;
    code_nxt  = code_r;
    last_nxt  = last_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt = GRANT;
          valid_nxt = 1'b1;
          code_nxt  = pick_idx_s;
        end else begin
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (ack_in) begin
          last_nxt = code_r;
          if (pick_any_s) begin
            valid_nxt = 1'b1;
            code_nxt  = pick_idx_s;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end else begin
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State, pending and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= 8'h00;
      valid_r   <= 1'b0;
      code_r    <= 3'd0;
      last_r    <= 3'd7;
    end else begin
      state_r   <= state_nxt;
      pending_r <= pending_nxt;
      valid_r   <= valid_nxt;
      code_r    <= code_nxt;
      last_r    <= last_nxt;
    end
  end

  assign valid_out   = valid_r;
  assign code_out    = code_r;
  assign pending_out = pending_r;

endmodule

// File: tb/tb_encoder_8_3_pending.sv
// Self-checking bench: fixed-priority and round-robin instances against a behavioural model.
module tb_encoder_8_3_pending;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask_in;
  logic       ack_in;
  logic       f_valid, r_valid;
  logic [2:0] f_code, r_code;
  logic [7:0] f_pend, r_pend;

  int checks;
  int errors;

  logic [7:0] m_pend  [2];
  logic       m_valid [2];
  logic [2:0] m_code  [2];
  logic [2:0] m_last  [2];

  encoder_8_3_pending #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_in(mask_in), .ack_in(ack_in),
    .valid_out(f_valid), .code_out(f_code), .pending_out(f_pend)
  );

  encoder_8_3_pending #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_in(mask_in), .ack_in(ack_in),
    .valid_out(r_valid), .code_out(r_code), .pending_out(r_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fixed mode: highest set index. Rotating mode: nearest set index going upward from 'from'.
  function automatic logic [2:0] ref_select(input logic [7:0] e, input logic [2:0] from, input bit rr);
    int j;
    ref_select = 3'd0;
    if (!rr) begin
      for (int i = 0; i < 8; i++) if (e[i]) ref_select = 3'(i);
    end else begin
      for (int k = 8; k >= 1; k--) begin
        j = (int'(from) + k) % 8;
        if (e[j]) ref_select = 3'(j);
      end
    end
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = 8'h00;
      m_valid[m] = 1'b0;
      m_code[m]  = 3'd0;
      m_last[m]  = 3'd7;
    end
  endtask

  task automatic model_step(input int m);
    logic [7:0] np, e;
    bit rr;
    rr = (m == 1);
    np = m_pend[m];
    if (m_valid[m] && ack_in) np[m_code[m]] = 1'b0;
    np = np | req_in;
    if (!m_valid[m]) begin
      e = m_pend[m] & ~mask_in;
      if (e != 8'h00) begin
        m_valid[m] = 1'b1;
        m_code[m]  = ref_select(e, m_last[m], rr);
      end
    end else if (ack_in) begin
      m_last[m] = m_code[m];
      e = np & ~mask_in;
      if (e != 8'h00) m_code[m] = ref_select(e, m_last[m], rr);
      else            m_valid[m] = 1'b0;
    end
    m_pend[m] = np;
  endtask

  task automatic check_all();
    check_eq("fp_valid", {7'd0, f_valid}, {7'd0, m_valid[0]});
    check_eq("fp_code",  {5'd0, f_code},  {5'd0, m_code[0]});
    check_eq("fp_pend",  f_pend,  m_pend[0]);
    check_eq("rr_valid", {7'd0, r_valid}, {7'd0, m_valid[1]});
    check_eq("rr_code",  {5'd0, r_code},  {5'd0, m_code[1]});
    check_eq("rr_pend",  r_pend,  m_pend[1]);
  endtask

  // Advance one rising edge from a falling edge; checks the model afterwards.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_fv"}, {7'd0, f_valid}, 8'h00);
    check_eq({tag, "_fc"}, {5'd0, f_code}, 8'h00);
    check_eq({tag, "_fp"}, f_pend, 8'h00);
    check_eq({tag, "_rv"}, {7'd0, r_valid}, 8'h00);
    check_eq({tag, "_rc"}, {5'd0, r_code}, 8'h00);
    check_eq({tag, "_rp"}, r_pend, 8'h00);
  endtask

  task automatic drain();
    req_in = 8'h00; mask_in = 8'h00; ack_in = 1'b1;
    repeat (10) cycle();
    ack_in = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; req_in = 8'hFF; mask_in = 8'h00; ack_in = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (2) cycle();
    check_zero("reset");

    // Release; 2-cycle request-to-grant
    rst_n = 1'b1; req_in = 8'h10;
    cycle();
    check_eq("t1_pend", f_pend, 8'h10);
    check_eq("t1_nv", {7'd0, f_valid}, 8'h00);
    req_in = 8'h00;
    cycle();
    check_eq("t1_valid", {7'd0, f_valid}, 8'h01);
    check_eq("t1_code", {5'd0, f_code}, 8'd4);
    check_eq("t1_rcode", {5'd0, r_code}, 8'd4);
    drain();

    // Fixed priority back-to-back
    req_in = 8'h25; cycle();
    req_in = 8'h00; ack_in = 1'b1;
    cycle(); check_eq("t2_c5", {5'd0, f_code}, 8'd5);
    cycle(); check_eq("t2_c2", {5'd0, f_code}, 8'd2);
    check_eq("t2_v2", {7'd0, f_valid}, 8'h01);
    cycle(); check_eq("t2_c0", {5'd0, f_code}, 8'd0);
    cycle();
    check_eq("t2_v", {7'd0, f_valid}, 8'h00);
    check_eq("t2_p", f_pend, 8'h00);
    drain();

    // No preemption while unacknowledged
    req_in = 8'h02; cycle();
    req_in = 8'h00; cycle();
    check_eq("t3_c1", {5'd0, f_code}, 8'd1);
    req_in = 8'h80; cycle();
    req_in = 8'h00; cycle();
    check_eq("t3_hold", {5'd0, f_code}, 8'd1);
    check_eq("t3_pend", f_pend, 8'h82);
    ack_in = 1'b1; cycle();
    check_eq("t3_c7", {5'd0, f_code}, 8'd7);
    check_eq("t3_v7", {7'd0, f_valid}, 8'h01);
    drain();

    // Round-robin wrap with continuously re-asserted requests
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    req_in = 8'h81; ack_in = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("t4_rr", {5'd0, r_code}, (i % 2 == 0) ? 8'd0 : 8'd7);
      check_eq("t4_pend", r_pend, 8'h81);
    end
    drain();

    // Masked lines stay pending until unmasked
    req_in = 8'h0C; mask_in = 8'h08; cycle();
    req_in = 8'h00; cycle();
    check_eq("t5_c2", {5'd0, f_code}, 8'd2);
    ack_in = 1'b1; cycle();
    check_eq("t5_nv", {7'd0, f_valid}, 8'h00);
    check_eq("t5_pend", f_pend, 8'h08);
    ack_in = 1'b0; mask_in = 8'h00; cycle();
    check_eq("t5_c3", {5'd0, f_code}, 8'd3);
    check_eq("t5_v3", {7'd0, f_valid}, 8'h01);
    drain();

    // Asynchronous reset in the middle of a grant
    req_in = 8'h43; cycle();
    req_in = 8'h00; cycle();
    check_eq("t6_v", {7'd0, f_valid}, 8'h01);
    check_eq("t6_c", {5'd0, f_code}, 8'd6);
    check_eq("t6_p", f_pend, 8'h43);
    #2 rst_n = 1'b0;
    #1 check_zero("t6_async");
    model_reset();
    @(negedge clk);
    check_zero("t6_after");
    rst_n = 1'b1;

    // Randomised traffic, with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      req_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mask_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ack_in  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_zero("rnd_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
